// File: rtl/hb3_feedback.sv
// hb3_feedback: HB3 Hall-sensor quadrature decoder.
// Synchronizes SA/SB, tracks a signed wrapping position and the rotation direction,
// flags illegal double transitions, and reports edges per fixed gate window as speed.
module hb3_feedback #(
  parameter int unsigned GATE_CYCLES = 100000,
  parameter int unsigned POS_WIDTH   = 16,
  parameter int unsigned SPD_WIDTH   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sa,
  input  logic                 sb,
  input  logic                 clear,
  output logic [POS_WIDTH-1:0] position,
  output logic                 direction,
  output logic [SPD_WIDTH-1:0] speed,
  output logic                 speed_valid,
  output logic                 moving,
  output logic                 error
);

  localparam int unsigned          GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0]    GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SPD_WIDTH-1:0] SPD_MAX   = '1;

  logic                 r_sa_meta;
  logic                 r_sa_sync;
  logic                 r_sb_meta;
  logic                 r_sb_sync;
  logic [1:0]           r_ab_prev;
  logic                 r_primed;
  logic [POS_WIDTH-1:0] r_position;
  logic                 r_direction;
  logic                 r_error;
  logic [GATE_W-1:0]    r_gate;
  logic [SPD_WIDTH-1:0] r_edge_cnt;
  logic [SPD_WIDTH-1:0] r_speed;
  logic                 r_speed_valid;
  logic                 r_moving;

  logic [1:0]           w_cur;
  logic                 w_fwd;
  logic                 w_rev;
  logic                 w_illegal;
  logic                 w_edge;
  logic                 w_terminal;
  logic [SPD_WIDTH:0]   w_edge_sum;
  logic [SPD_WIDTH-1:0] w_edge_sat;

  assign w_cur      = {r_sa_sync, r_sb_sync};
  assign w_edge     = w_fwd | w_rev;
  assign w_terminal = (r_gate == GATE_LAST);
  // Edge count plus this cycle's edge, clamped; the counter never exceeds max so +1 overflow is the only case.
  assign w_edge_sum = {1'b0, r_edge_cnt} + (SPD_WIDTH + 1)'(w_edge);
  assign w_edge_sat = w_edge_sum[SPD_WIDTH] ? SPD_MAX : w_edge_sum[SPD_WIDTH-1:0];

  // Two-flop synchronizers for the asynchronous sensor pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa_meta <= 1'b0;
      r_sa_sync <= 1'b0;
      r_sb_meta <= 1'b0;
      r_sb_sync <= 1'b0;
    end else begin
      r_sa_meta <= sa;
      r_sa_sync <= r_sa_meta;
      r_sb_meta <= sb;
      r_sb_sync <= r_sb_meta;
    end
  end

  // Classify the previous->current Gray transition (A leads B = forward).
  always_comb begin
    w_fwd     = 1'b0;
    w_rev     = 1'b0;
    w_illegal = 1'b0;
    if (r_primed) begin
      case ({r_ab_prev, w_cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_fwd     = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_rev     = 1'b1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: w_illegal = 1'b1;
        default: ;
      endcase
    end
  end

  // Previous-state register; the first cycle after reset only primes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ab_prev <= 2'b00;
      r_primed  <= 1'b0;
    end else begin
      r_ab_prev <= w_cur;
      r_primed  <= 1'b1;
    end
  end

  // Position, direction and sticky error; clear wins over a same-cycle step or error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_position  <= '0;
      r_direction <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (clear) begin
        r_position <= '0;
      end else if (w_fwd) begin
        r_position <= r_position + POS_WIDTH'(1);
      end else if (w_rev) begin
        r_position <= r_position - POS_WIDTH'(1);
      end

      if (w_fwd) begin
        r_direction <= 1'b1;
      end else if (w_rev) begin
        r_direction <= 1'b0;
      end

      if (clear) begin
        r_error <= 1'b0;
      end else if (w_illegal) begin
        r_error <= 1'b1;
      end
    end
  end

  // Free-running gate counter defining the speed window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate <= '0;
    end else if (w_terminal) begin
      r_gate <= '0;
    end else begin
      r_gate <= r_gate + GATE_W'(1);
    end
  end

  // Per-window edge counting and speed/moving publication on the terminal cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt    <= '0;
      r_speed       <= '0;
      r_speed_valid <= 1'b0;
      r_moving      <= 1'b0;
    end else if (w_terminal) begin
      r_edge_cnt    <= '0;
      r_speed       <= w_edge_sat;
      r_speed_valid <= 1'b1;
      r_moving      <= (w_edge_sat != '0);
    end else begin
      r_edge_cnt    <= w_edge_sat;
      r_speed_valid <= 1'b0;
    end
  end

  assign position    = r_position;
  assign direction   = r_direction;
  assign speed       = r_speed;
  assign speed_valid = r_speed_valid;
  assign moving      = r_moving;
  assign error       = r_error;

endmodule
